// File: rtl/av_bridge_pkg.sv
// -----------------------------------------------------------------------------
// av_bridge_pkg
// Shared definitions for the Avalon-MM master bridge: the bridge FSM state
// type and the bit positions of the status and control registers.
// -----------------------------------------------------------------------------
package av_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_READ    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // status_q layout
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_TMO_ERR = 2;
    localparam int unsigned STAT_OVF_ERR = 3;
    localparam int unsigned STAT_AUTOINC = 4;
    localparam int unsigned STAT_CNT_LSB = 8;
    localparam int unsigned STAT_CNT_W   = 4;

    // ld_ctrl data layout
    localparam int unsigned CTRL_AUTOINC = 0;
    localparam int unsigned CTRL_CLR_ERR = 1;

endpackage

// File: rtl/av_wfifo.sv
// -----------------------------------------------------------------------------
// av_wfifo
// Synchronous posted-write FIFO. Push while full and pop while empty are
// ignored. Asynchronous active-low reset empties the FIFO.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push/i_wdata : write an entry
//   i_pop          : discard the head entry
//   o_rdata        : head entry (valid when !o_empty)
//   o_count        : number of stored entries (0..DEPTH)
//   o_full/o_empty : occupancy flags
// -----------------------------------------------------------------------------
module av_wfifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/av_mm_bridge.sv
// -----------------------------------------------------------------------------
// av_mm_bridge
// Avalon-MM master bridge between the MCU register file and the interconnect.
// Writes are posted through a FIFO; reads are ordered behind queued writes.
// Optional address auto-increment, waitrequest timeout with sticky errors.
//   sysclk, sysreset_n      : clock, async active-low reset
//   load_data               : MCU register-load bus
//   ld_ad_hi / ld_ad_lo     : load upper / lower address register
//   ld_wdata                : post {address, load_data} into the write FIFO
//   rd_trigger              : start an Avalon read at the current address
//   ld_ctrl                 : bit0 auto_inc, bit1 clear errors (W1C)
//   ad_hi_q, ad_lo_q        : address registers
//   rdata_q                 : last captured read data
//   status_q                : busy/empty/errors/auto_inc/fifo count
//   mcu_wait                : MCU stall (FIFO full or read outstanding)
//   av_*                    : Avalon-MM master interface
// -----------------------------------------------------------------------------
module av_mm_bridge
    import av_bridge_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WFIFO_DEPTH = 4,
    parameter int unsigned ADDR_STEP   = 2,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic                     sysclk,
    input  logic                     sysreset_n,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     ld_ad_hi,
    input  logic                     ld_ad_lo,
    input  logic                     ld_wdata,
    input  logic                     rd_trigger,
    input  logic                     ld_ctrl,
    output logic [ADDR_W-DATA_W-1:0] ad_hi_q,
    output logic [DATA_W-1:0]        ad_lo_q,
    output logic [DATA_W-1:0]        rdata_q,
    output logic [DATA_W-1:0]        status_q,
    output logic                     mcu_wait,
    output logic [ADDR_W-1:0]        av_address,
    output logic                     av_read,
    output logic                     av_write,
    output logic [DATA_W-1:0]        av_writedata,
    input  logic [DATA_W-1:0]        av_readdata,
    input  logic                     av_waitrequest
);

    localparam int unsigned HI_W  = ADDR_W - DATA_W;
    localparam int unsigned CNT_W = $clog2(WFIFO_DEPTH) + 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HI_W-1:0]     r_ad_hi;
    logic [DATA_W-1:0]   r_ad_lo;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rd_pending;
    logic                r_auto_inc;
    logic                r_tmo_err;
    logic                r_ovf_err;
    logic [TMO_W-1:0]    r_tmo_cnt;

    logic [ADDR_W-1:0]        w_addr;
    logic [ADDR_W-1:0]        w_addr_inc;
    logic                     w_push_ok;
    logic                     w_rd_ok;
    logic                     w_inc;
    logic                     w_pop;
    logic                     w_tmo_hit;
    logic                     w_tmo_abort;
    logic                     w_rd_done;
    logic                     w_rd_abort;
    logic                     w_av_read;
    logic                     w_av_write;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [CNT_W-1:0]         w_count;
    logic                     w_full;
    logic                     w_empty;

    assign w_addr     = {r_ad_hi, r_ad_lo};
    assign w_addr_inc = w_addr + ADDR_W'(ADDR_STEP);
    assign w_push_ok  = ld_wdata && !w_full;
    assign w_rd_ok    = rd_trigger && !r_rd_pending;
    // Any address-register load in the same cycle suppresses the increment.
    assign w_inc      = r_auto_inc && (w_push_ok || w_rd_ok) && !(ld_ad_hi || ld_ad_lo);
    assign w_tmo_hit  = (TIMEOUT != 0) && av_waitrequest &&
                        (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    av_wfifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .i_clk   (sysclk),
        .i_rst_n (sysreset_n),
        .i_push  (w_push_ok),
        .i_pop   (w_pop),
        .i_wdata ({w_addr, load_data}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_av_read   = 1'b0;
        w_av_write  = 1'b0;
        w_tmo_abort = 1'b0;
        w_rd_done   = 1'b0;
        w_rd_abort  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_WRITE;
                end else if (r_rd_pending) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_WRITE: begin
                w_av_write = 1'b1;
                if (!av_waitrequest || w_tmo_hit) begin
                    w_pop       = 1'b1;
                    w_tmo_abort = av_waitrequest;
                    w_state_nxt = ((w_count > CNT_W'(1)) || w_push_ok) ? ST_WRITE : ST_IDLE;
                end
            end
            ST_READ: begin
                w_av_read = 1'b1;
                if (!av_waitrequest) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end else if (w_tmo_hit) begin
                    w_rd_abort  = 1'b1;
                    w_tmo_abort = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Timeout counter restarts on every state change and on every pop, so each
    // back-to-back write gets its own full waitrequest budget.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            r_tmo_cnt <= '0;
        end else if ((r_state != w_state_nxt) || w_pop) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_WRITE || r_state == ST_READ) && av_waitrequest) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            r_ad_hi      <= '0;
            r_ad_lo      <= '0;
            r_rd_addr    <= '0;
            r_rdata      <= '0;
            r_rd_pending <= 1'b0;
            r_auto_inc   <= 1'b0;
            r_tmo_err    <= 1'b0;
            r_ovf_err    <= 1'b0;
        end else begin
            if (w_inc) begin
                {r_ad_hi, r_ad_lo} <= w_addr_inc;
            end
            if (ld_ad_lo) begin
                r_ad_lo <= load_data;
            end
            if (ld_ad_hi) begin
                r_ad_hi <= load_data[HI_W-1:0];
            end

            if (w_rd_ok) begin
                r_rd_pending <= 1'b1;
                r_rd_addr    <= w_addr;
            end else if (r_state == ST_CAPTURE) begin
                r_rd_pending <= 1'b0;
            end

            if (w_rd_done) begin
                r_rdata <= av_readdata;
            end else if (w_rd_abort) begin
                r_rdata <= '1;
            end

            if (ld_ctrl) begin
                r_auto_inc <= load_data[CTRL_AUTOINC];
            end

            // Setting an error wins over a same-cycle clear.
            if (w_tmo_abort) begin
                r_tmo_err <= 1'b1;
            end else if (ld_ctrl && load_data[CTRL_CLR_ERR]) begin
                r_tmo_err <= 1'b0;
            end

            if (ld_wdata && w_full) begin
                r_ovf_err <= 1'b1;
            end else if (ld_ctrl && load_data[CTRL_CLR_ERR]) begin
                r_ovf_err <= 1'b0;
            end
        end
    end

    always_comb begin
        status_q                                 = '0;
        status_q[STAT_BUSY]                      = (r_state != ST_IDLE) || !w_empty || r_rd_pending;
        status_q[STAT_EMPTY]                     = w_empty;
        status_q[STAT_TMO_ERR]                   = r_tmo_err;
        status_q[STAT_OVF_ERR]                   = r_ovf_err;
        status_q[STAT_AUTOINC]                   = r_auto_inc;
        status_q[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(w_count);
    end

    assign ad_hi_q      = r_ad_hi;
    assign ad_lo_q      = r_ad_lo;
    assign rdata_q      = r_rdata;
    assign mcu_wait     = w_full | r_rd_pending;
    assign av_read      = w_av_read;
    assign av_write     = w_av_write;
    assign av_address   = (r_state == ST_READ) ? r_rd_addr : w_head[ADDR_W+DATA_W-1 -: ADDR_W];
    assign av_writedata = w_head[DATA_W-1:0];

endmodule

// File: tb/tb_av_mm_bridge.sv
// -----------------------------------------------------------------------------
// tb_av_mm_bridge
// Scoreboard bench for av_mm_bridge. The MCU driver computes the expected
// Avalon transactions from a transaction-level address/flag model and queues
// them; an independent monitor pops and compares whenever the bridge completes
// or aborts an Avalon access.
// -----------------------------------------------------------------------------
module tb_av_mm_bridge;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned STEP  = 2;
    localparam int unsigned TMO   = 15;

    logic          sysclk = 1'b0;
    logic          sysreset_n;
    logic [DW-1:0] load_data;
    logic          ld_ad_hi, ld_ad_lo, ld_wdata, rd_trigger, ld_ctrl;
    logic [AW-DW-1:0] ad_hi_q;
    logic [DW-1:0] ad_lo_q, rdata_q, status_q;
    logic          mcu_wait;
    logic [AW-1:0] av_address;
    logic          av_read, av_write;
    logic [DW-1:0] av_writedata;
    logic [DW-1:0] av_readdata;
    logic          av_waitrequest;

    always #5 sysclk = ~sysclk;

    av_mm_bridge #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .WFIFO_DEPTH (DEPTH),
        .ADDR_STEP   (STEP),
        .TIMEOUT     (TMO)
    ) dut (
        .sysclk         (sysclk),
        .sysreset_n     (sysreset_n),
        .load_data      (load_data),
        .ld_ad_hi       (ld_ad_hi),
        .ld_ad_lo       (ld_ad_lo),
        .ld_wdata       (ld_wdata),
        .rd_trigger     (rd_trigger),
        .ld_ctrl        (ld_ctrl),
        .ad_hi_q        (ad_hi_q),
        .ad_lo_q        (ad_lo_q),
        .rdata_q        (rdata_q),
        .status_q       (status_q),
        .mcu_wait       (mcu_wait),
        .av_address     (av_address),
        .av_read        (av_read),
        .av_write       (av_write),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest)
    );

    typedef struct {
        bit            is_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_tmo  = 0;      // aborts seen by the monitor
    int   tmo_mark = 0;    // n_tmo at the last error clear
    int   wmode  = 0;      // 0: no wait, 1: random wait, 2: wait held
    bit   rd_fixed = 1'b0;

    // Reference model state (MCU-visible registers)
    logic [AW-1:0] m_a;
    bit            m_auto;
    bit            m_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_idle_status();
        logic [DW-1:0] s;
        s    = '0;
        s[1] = 1'b1;
        s[2] = (n_tmo != tmo_mark);
        s[3] = m_ovf;
        s[4] = m_auto;
        return s;
    endfunction

    // Avalon slave: waitrequest and readdata change just after each edge.
    initial begin
        av_waitrequest = 1'b0;
        av_readdata    = '0;
        forever begin
            @(posedge sysclk);
            #1;
            av_readdata = rd_fixed ? DW'(16'h1234) : DW'($urandom);
            case (wmode)
                0:       av_waitrequest = 1'b0;
                1:       av_waitrequest = ($urandom_range(0, 9) < 3);
                default: av_waitrequest = 1'b1;
            endcase
        end
    end

    // Monitor: a transfer completes at the edge following a sample with
    // waitrequest low, or aborts after TMO consecutive waitrequest samples.
    initial begin
        int            wcnt;
        bit            rd_chk;
        bit            done;
        bit            abort;
        logic [DW-1:0] rd_exp;
        txn_t          t;
        wcnt   = 0;
        rd_chk = 1'b0;
        rd_exp = '0;
        forever begin
            @(negedge sysclk);
            if (!sysreset_n) begin
                wcnt   = 0;
                rd_chk = 1'b0;
            end else begin
                if (rd_chk) begin
                    check("rdata_q_after_read", rdata_q, rd_exp);
                    rd_chk = 1'b0;
                end
                if (av_write || av_read) begin
                    done  = !av_waitrequest;
                    abort = 1'b0;
                    if (!done) begin
                        wcnt++;
                        abort = (wcnt == TMO);
                    end
                    if (done || abort) begin
                        wcnt = 0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_txn", av_address, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            t = exp_q.pop_front();
                            check("txn_kind", av_read, t.is_rd);
                            check("txn_addr", av_address, t.addr);
                            if (!t.is_rd) check("txn_wdata", av_writedata, t.data);
                            if (av_read) begin
                                rd_chk = 1'b1;
                                rd_exp = abort ? '1 : av_readdata;
                            end
                            if (abort) n_tmo++;
                        end
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    // One MCU register access cycle; updates the model and the scoreboard.
    task automatic mcu_op(input bit hi, input bit lo, input bit w, input bit r,
                          input bit c, input bit drop, input logic [DW-1:0] d);
        txn_t t;
        ld_ad_hi   = hi;
        ld_ad_lo   = lo;
        ld_wdata   = w;
        rd_trigger = r;
        ld_ctrl    = c;
        load_data  = d;
        if (w && !drop) begin
            t.is_rd = 1'b0; t.addr = m_a; t.data = d;
            exp_q.push_back(t);
        end
        if (r) begin
            t.is_rd = 1'b1; t.addr = m_a; t.data = '0;
            exp_q.push_back(t);
        end
        if (m_auto && ((w && !drop) || r) && !(hi || lo)) m_a = m_a + AW'(STEP);
        if (lo) m_a[DW-1:0] = d;
        if (hi) m_a[AW-1:DW] = d[AW-DW-1:0];
        if (c) begin
            m_auto = d[0];
            if (d[1]) begin
                m_ovf    = 1'b0;
                tmo_mark = n_tmo;
            end
        end
        if (w && drop) m_ovf = 1'b1;
        tick();
        ld_ad_hi = 0; ld_ad_lo = 0; ld_wdata = 0; rd_trigger = 0; ld_ctrl = 0;
        check("ad_hi_q", ad_hi_q, m_a[AW-1:DW]);
        check("ad_lo_q", ad_lo_q, m_a[DW-1:0]);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 500 && mcu_wait; i++) tick();
        check("wait_ready_bound", mcu_wait, 0);
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (!status_q[0] && exp_q.size() == 0) break;
            tick();
        end
        check({name, "_idle_bound"}, (i < 2000), 1);
        check({name, "_idle_status"}, status_q, exp_idle_status());
    endtask

    task automatic model_reset();
        m_a      = '0;
        m_auto   = 1'b0;
        m_ovf    = 1'b0;
        tmo_mark = n_tmo;
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        int            op;
        logic [DW-1:0] d;

        sysreset_n = 1'b0;
        load_data = '0; ld_ad_hi = 0; ld_ad_lo = 0; ld_wdata = 0; rd_trigger = 0; ld_ctrl = 0;
        model_reset();
        repeat (3) tick();
        check("rst_av_read", av_read, 0);
        check("rst_av_write", av_write, 0);
        check("rst_mcu_wait", mcu_wait, 0);
        check("rst_status", status_q, 16'h0002);
        check("rst_addr", {ad_hi_q, ad_lo_q}, 0);
        check("rst_rdata", rdata_q, 0);
        sysreset_n = 1'b1;
        tick();

        // 1: single posted write, no waitrequest
        wmode = 0;
        mcu_op(0, 1, 0, 0, 0, 0, 16'h0100);
        mcu_op(1, 0, 0, 0, 0, 0, 16'h0000);
        mcu_op(0, 0, 1, 0, 0, 0, 16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            check("t1_mcu_wait", mcu_wait, 0);
            tick();
        end
        wait_idle("t1");

        // 2: auto-increment, fill the FIFO against held waitrequest
        mcu_op(0, 0, 0, 0, 1, 0, 16'h0001);
        mcu_op(0, 1, 0, 0, 0, 0, 16'h0100);
        wmode = 2;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            mcu_op(0, 0, 1, 0, 0, 0, DW'($urandom));
            check("t2_mcu_wait", mcu_wait, (i == 3));
        end
        check("t2_fifo_count", status_q[11:8], 4);
        wmode = 0;
        wait_ready();
        mcu_op(0, 0, 1, 0, 0, 0, DW'($urandom));
        wait_idle("t2");
        check("t2_final_addr", ad_lo_q, 16'h010A);

        // overflow: push while full is dropped and flagged
        wmode = 2;
        tick(); tick();
        for (int i = 0; i < 4; i++) mcu_op(0, 0, 1, 0, 0, 0, DW'($urandom));
        mcu_op(0, 0, 1, 0, 0, 1, DW'($urandom));
        check("ovf_flag", status_q[3], 1);
        wmode = 0;
        wait_idle("ovf");
        mcu_op(0, 0, 0, 0, 1, 0, 16'h0003);
        check("ovf_cleared", status_q[3], 0);

        // 3: read ordered behind two queued writes
        wmode = 1;
        rd_fixed = 1'b1;
        mcu_op(0, 1, 0, 0, 0, 0, 16'h0300);
        wait_ready(); mcu_op(0, 0, 1, 0, 0, 0, 16'hA5A5);
        wait_ready(); mcu_op(0, 0, 1, 0, 0, 0, 16'h5A5A);
        wait_ready(); mcu_op(0, 1, 0, 0, 0, 0, 16'h0200);
        wait_ready(); mcu_op(0, 0, 0, 1, 0, 0, 16'h0000);
        wait_idle("t3");
        check("t3_rdata", rdata_q, 16'h1234);
        rd_fixed = 1'b0;

        // read and write latency with no waitrequest
        wmode = 0;
        tick(); tick();
        mcu_op(0, 0, 0, 0, 1, 0, 16'h0000);
        mcu_op(0, 0, 0, 1, 0, 0, 16'h0000);
        check("lat_rd_n0_read", av_read, 0);
        check("lat_rd_n0_wait", mcu_wait, 1);
        tick();
        check("lat_rd_n1_read", av_read, 1);
        tick();
        check("lat_rd_n2_read", av_read, 0);
        check("lat_rd_n2_wait", mcu_wait, 1);
        tick();
        check("lat_rd_n3_wait", mcu_wait, 0);
        mcu_op(0, 0, 1, 0, 0, 0, 16'h7777);
        check("lat_wr_n0_write", av_write, 0);
        tick();
        check("lat_wr_n1_write", av_write, 1);
        tick();
        check("lat_wr_n2_write", av_write, 0);
        check("lat_wr_n2_empty", status_q[1], 1);

        // 4: read timeout
        wmode = 2;
        tick(); tick();
        mcu_op(0, 1, 0, 0, 0, 0, 16'h0400);
        mcu_op(0, 0, 0, 1, 0, 0, 16'h0000);
        for (int i = 0; i < 10 && !av_read; i++) tick();
        n = 0;
        while (av_read && n < 100) begin
            n++;
            tick();
        end
        check("t4_read_cycles", n, TMO);
        wmode = 0;
        wait_idle("t4");
        check("t4_rdata", rdata_q, 16'hFFFF);
        check("t4_tmo_err", status_q[2], 1);
        mcu_op(0, 0, 0, 0, 1, 0, 16'h0002);
        check("t4_tmo_cleared", status_q[2], 0);

        // write timeout discards the entry
        wmode = 2;
        tick(); tick();
        mcu_op(0, 0, 1, 0, 0, 0, 16'hDEAD);
        wait_idle("t4w");
        check("t4w_tmo_err", status_q[2], 1);
        wmode = 0;
        mcu_op(0, 0, 0, 0, 1, 0, 16'h0002);

        // 5: carry from lo into hi
        mcu_op(0, 0, 0, 0, 1, 0, 16'h0001);
        mcu_op(0, 1, 0, 0, 0, 0, 16'hFFFE);
        mcu_op(1, 0, 0, 0, 0, 0, 16'h0001);
        mcu_op(0, 0, 1, 0, 0, 0, 16'h1111);
        check("t5_hi", ad_hi_q, 16'h0002);
        check("t5_lo", ad_lo_q, 16'h0000);
        wait_idle("t5");

        // randomized traffic
        wmode = 1;
        for (int k = 0; k < 200; k++) begin
            wait_ready();
            op = $urandom_range(0, 11);
            d  = DW'($urandom);
            case (op)
                0:       mcu_op(0, 1, 0, 0, 0, 0, d);
                1:       mcu_op(1, 0, 0, 0, 0, 0, d);
                2:       mcu_op(0, 0, 0, 0, 1, 0, d & 16'h0003);
                3, 4, 5: mcu_op(0, 0, 1, 0, 0, 0, d);
                6, 7:    mcu_op(0, 0, 0, 1, 0, 0, d);
                8:       mcu_op(0, 0, 1, 1, 0, 0, d);
                9:       mcu_op(0, 1, 1, 0, 0, 0, d);
                10:      mcu_op(1, 0, 0, 1, 0, 0, d);
                default: mcu_op(0, 0, 0, 0, 1, 0, 16'h0001);
            endcase
        end
        wait_idle("rand");

        // 6: asynchronous reset in the middle of a stalled write
        wmode = 2;
        tick(); tick();
        mcu_op(0, 0, 1, 0, 0, 0, 16'hCAFE);
        for (int i = 0; i < 5 && !av_write; i++) tick();
        check("t6_write_active", av_write, 1);
        #2;
        sysreset_n = 1'b0;
        #1;
        check("t6_av_write", av_write, 0);
        check("t6_mcu_wait", mcu_wait, 0);
        check("t6_status", status_q, 16'h0002);
        model_reset();
        tick();
        sysreset_n = 1'b1;
        wmode = 0;
        tick();
        mcu_op(0, 1, 0, 0, 0, 0, 16'h0042);
        mcu_op(0, 0, 1, 0, 0, 0, 16'h4242);
        wait_idle("t6");
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
